parity_reader: RTL

//   Receive end of the writer link. Samples the {parity, data} word driven by the writer,

---
 rtl/parity_reader_if.sv | 20 ++
 rtl/parity_reader.sv | 90 +++++++++
 2 files changed

// File: rtl/parity_reader_if.sv
// Writer-to-reader word link plus the consumer-side valid/ready read port of parity_reader.
interface parity_reader_if #(
    parameter int DWIDTH = 10
);
    logic              vld;
    logic [DWIDTH:0]   in;
    logic [DWIDTH-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output vld, in, dout_ready,
        input  dout, dout_valid
    );

    modport slave (
        input  vld, in, dout_ready,
        output dout, dout_valid
    );
endinterface

// File: rtl/parity_reader.sv
// Parity-checks writer words and queues good ones in a FWFT FIFO; a pushed word is at dout from the push edge.
// Backpressure: dout_ready stalls the FIFO; a good word arriving when full with no pop is dropped and ovf latches.
module parity_reader #(
    parameter int DWIDTH = 10,
    parameter int VWIDTH = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    parity_reader_if.slave           bus,
    output logic [VWIDTH-1:0]        cnt,
    output logic [VWIDTH-1:0]        err_cnt,
    output logic                     par_err,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;

    logic parity_ok;
    logic good;
    logic bad;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign parity_ok = (bus.in[DWIDTH] == ^bus.in[DWIDTH-1:0]);
    assign good      = bus.vld && parity_ok;
    assign bad       = bus.vld && !parity_ok;
    assign full      = (level == LW'(DEPTH));
    assign pop       = bus.dout_valid && bus.dout_ready;
    // A pop in the same cycle frees the slot the full-FIFO push needs.
    assign push      = good && (!full || pop);
    assign drop      = good && full && !pop;

    assign bus.dout_valid = (level != '0);
    assign bus.dout       = bus.dout_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= bus.in[DWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            par_err <= 1'b0;
            ovf     <= 1'b0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            par_err <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            par_err <= bad;
            if (bad && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule
